chunked_seq_adder: RTL and testbench

Multi-cycle, parametrised successor to the single-bit full adder. It adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, rippling the carry through an internal carry register. This trades latency for a narrow adder datapath. It sits beside the existing combinational adder cells and serves datapaths that tolerate a start/done handshake.

---
 rtl/chunked_seq_adder.sv | 103 ++++++++++
 tb/tb_chunked_seq_adder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/chunked_seq_adder.sv
// rtl/chunked_seq_adder.sv - multi-cycle add/sub, DIGIT bits per clock via a carry register.
// Optional zero/ovf result flags enabled by CHUNKED_SEQ_ADDER_FLAGS_EN.
module chunked_seq_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef CHUNKED_SEQ_ADDER_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({DIGIT{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  op_a, op_b, partial, partial_next;
  logic              carry;
  logic [CW-1:0]     cnt;
  logic              last;
  logic              accept;
  logic [DIGIT-1:0]  a_chunk, b_chunk, s_chunk;
  logic              c_chunk;
  int unsigned       shamt;

  assign last   = (cnt == CW'(N - 1));
  assign accept = start && (state != S_RUN);
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);

  // One DIGIT-wide slice of the narrow adder, selected by the chunk counter.
  always_comb begin
    shamt   = 32'(cnt) * DIGIT;
    a_chunk = DIGIT'(op_a >> shamt);
    b_chunk = DIGIT'(op_b >> shamt);
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{DIGIT{1'b0}}, carry};
    partial_next = (partial & ~(CHUNK_MASK << shamt)) | (WIDTH'(s_chunk) << shamt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last)  state_next = S_DONE;
      S_DONE:  state_next = start ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      partial <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef CHUNKED_SEQ_ADDER_FLAGS_EN
      zero    <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else if (accept) begin
      // Subtraction is a + ~b + 1, so the inversion and the +1 happen at capture.
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      partial <= partial_next;
      carry   <= c_chunk;
      cnt     <= cnt + 1'b1;
      if (last) begin
        sum  <= partial_next;
        cout <= c_chunk;
`ifdef CHUNKED_SEQ_ADDER_FLAGS_EN
        zero <= (partial_next == '0);
        ovf  <= c_chunk ^ (a_chunk[DIGIT-1] ^ b_chunk[DIGIT-1] ^ s_chunk[DIGIT-1]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// tb/tb_chunked_seq_adder.sv - self-checking bench for chunked_seq_adder (vectors, corners, random).
module tb_chunked_seq_adder;
  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic             cin = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;
`ifdef CHUNKED_SEQ_ADDER_FLAGS_EN
  logic             zero, ovf;
`endif

  chunked_seq_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum),
`ifdef CHUNKED_SEQ_ADDER_FLAGS_EN
    .zero(zero), .ovf(ovf),
`endif
    .cout(cout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] prev_sum = '0;
  logic             prev_cout = 1'b0;
  logic             prev_zero = 1'b0;
  logic             prev_ovf = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] va, vb;
    logic             vcin, vsub;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout, exp_zero, exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference from plain integer arithmetic on the operand values.
  task automatic model(input logic [WIDTH-1:0] ma, mb, input logic mcin, msub,
                       output logic [WIDTH-1:0] ms, output logic mc, mz, mo);
    int sa, sb, r;
    longint u;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      ms = ma - mb;
      mc = (ma >= mb);
      r  = sa - sb;
    end else begin
      u  = longint'(ma) + longint'(mb) + longint'(mcin);
      ms = u[WIDTH-1:0];
      mc = u[WIDTH];
      r  = sa + sb + int'(mcin);
    end
    mz = (ms == '0);
    mo = (r > (2**(WIDTH-1)) - 1) || (r < -(2**(WIDTH-1)));
  endtask

  task automatic run_op(input logic [WIDTH-1:0] ta, tb_, input logic tcin, tsub,
                        input int gap, input bit inject);
    logic [WIDTH-1:0] es;
    logic ec, ez, eo;
    int lat, busy_cnt;
    bit found;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); @(negedge clk);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
    end
    model(ta, tb_, tcin, tsub, es, ec, ez, eo);
    a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    busy_cnt = busy ? 1 : 0;
    check("sum_hold", sum, prev_sum);
    found = 0;
    lat = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      if (inject && k == 2) begin
        start = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom); sub = ~tsub;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      if (done) begin
        found = 1;
        lat = k;
      end else begin
        busy_cnt += busy ? 1 : 0;
        check("sum_hold", sum, prev_sum);
        check("cout_hold", cout, prev_cout);
      end
    end
    start = 1'b0;
    check("latency", lat, N);
    check("busy_cycles", busy_cnt, N);
    check("busy_in_done", busy, 0);
    check("sum", sum, es);
    check("cout", cout, ec);
`ifdef CHUNKED_SEQ_ADDER_FLAGS_EN
    check("zero", zero, ez);
    check("ovf", ovf, eo);
`endif
    prev_sum = es; prev_cout = ec; prev_zero = ez; prev_ovf = eo;
  endtask

  vec_t vecs[8];
  int   seen_done;

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Odd entries start from DONE (back-to-back), even ones after an idle gap.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, (i % 2 == 0) ? 1 : 0, 1'b0);
      check($sformatf("vec%0d_sum", i), sum, vecs[i].exp_sum);
      check($sformatf("vec%0d_cout", i), cout, vecs[i].exp_cout);
`ifdef CHUNKED_SEQ_ADDER_FLAGS_EN
      check($sformatf("vec%0d_zero", i), zero, vecs[i].exp_zero);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
`endif
    end

    // Start pulsed mid-RUN with other operands must not disturb the result.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1, 1'b1);
    check("inject_sum", sum, 16'h5555);

    // Asynchronous reset in the second RUN cycle abandons the operation.
    @(posedge clk); @(negedge clk);
    a = 16'hABCD; b = 16'h1111; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
`ifdef CHUNKED_SEQ_ADDER_FLAGS_EN
    check("midrst_zero", zero, 0);
    check("midrst_ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    prev_sum = '0; prev_cout = 1'b0; prev_zero = 1'b0; prev_ovf = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 2 * N + 2; k++) begin
      @(posedge clk); @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("no_done_after_rst", seen_done, 0);
    run_op(16'hABCD, 16'h1111, 1'b1, 1'b0, 0, 1'b0);
    check("post_rst_sum", sum, 16'hBCDF);

    for (int i = 0; i < 40; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 3) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
